// File: rtl/battleship_pkg.sv
// Shared Battleship board types: default board dimensions and the
// sunk-ship scanner state encoding.
package battleship_pkg;

    localparam int NUM_SHIPS_DEF = 5;
    localparam int SHIP_W_DEF    = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    // One ship row of the cell matrix; a 1 bit marks an intact cell.
    typedef logic [SHIP_W_DEF-1:0] ship_row_t;

endpackage

// File: rtl/sunk_ship_scanner.sv
// Sequential sunk-ship tracker: scans one ship row per cycle, keeps a sticky
// sunk mask/count, pulses newly sunk ships and flags game over at pass end.
module sunk_ship_scanner
    import battleship_pkg::*;
#(
    parameter int NUM_SHIPS = NUM_SHIPS_DEF,
    parameter int SHIP_W    = SHIP_W_DEF,
    parameter int IDX_W     = (NUM_SHIPS > 1) ? $clog2(NUM_SHIPS) : 1,
    parameter int CNT_W     = $clog2(NUM_SHIPS + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic                              start,
    input  logic [NUM_SHIPS-1:0][SHIP_W-1:0]  barcos,
    input  logic [NUM_SHIPS-1:0]              ship_valid,
    output logic                              busy,
    output logic                              done,
    output logic                              new_sunk,
    output logic [IDX_W-1:0]                  new_sunk_idx,
    output logic [NUM_SHIPS-1:0]              sunk_mask,
    output logic [CNT_W-1:0]                  sunk_count,
    output logic                              all_sunk
);

    scan_state_t            state, state_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt;
    logic                   busy_nxt, done_nxt, new_sunk_nxt, all_sunk_nxt;
    logic [IDX_W-1:0]       new_sunk_idx_nxt;
    logic [NUM_SHIPS-1:0]   sunk_mask_nxt;
    logic [CNT_W-1:0]       sunk_count_nxt;
    logic                   row_sunk_new;
    logic                   last_row;

    // A row is freshly destroyed only if it is in play and not already counted.
    assign row_sunk_new = ship_valid[idx] && (barcos[idx] == '0) && !sunk_mask[idx];
    assign last_row     = (idx == IDX_W'(NUM_SHIPS - 1));

    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt        = state;
        idx_nxt          = idx;
        sunk_mask_nxt    = sunk_mask;
        sunk_count_nxt   = sunk_count;
        all_sunk_nxt     = all_sunk;
        new_sunk_nxt     = 1'b0;
        new_sunk_idx_nxt = '0;
        done_nxt         = 1'b0;

        if (clear) begin
            state_nxt      = IDLE;
            idx_nxt        = '0;
            sunk_mask_nxt  = '0;
            sunk_count_nxt = '0;
            all_sunk_nxt   = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = SCAN;
                        idx_nxt   = '0;
                    end
                end
                SCAN: begin
                    if (row_sunk_new) begin
                        sunk_mask_nxt[idx] = 1'b1;
                        new_sunk_nxt       = 1'b1;
                        new_sunk_idx_nxt   = idx;
                        if (sunk_count < CNT_W'(NUM_SHIPS))
                            sunk_count_nxt = sunk_count + CNT_W'(1);
                    end
                    if (last_row) state_nxt = DONE;
                    else          idx_nxt   = idx + IDX_W'(1);
                end
                DONE: begin
                    done_nxt     = 1'b1;
                    all_sunk_nxt = (ship_valid != '0) &&
                                   ((sunk_mask & ship_valid) == ship_valid);
                    state_nxt    = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end

        busy_nxt = (state_nxt != IDLE);
    end

    // NOTE: reset is synchronous here, sampled only on the clock edge, and all
    // state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            new_sunk     <= 1'b0;
            new_sunk_idx <= '0;
            sunk_mask    <= '0;
            sunk_count   <= '0;
            all_sunk     <= 1'b0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            new_sunk     <= new_sunk_nxt;
            new_sunk_idx <= new_sunk_idx_nxt;
            sunk_mask    <= sunk_mask_nxt;
            sunk_count   <= sunk_count_nxt;
            all_sunk     <= all_sunk_nxt;
        end
    end

endmodule

// File: doc/sunk_ship_scanner.md
Name: sunk_ship_scanner

Overview:
- Sequential tracker of destroyed ships for the Battleship board logic.
- On each `start` it scans the ship-cell matrix one row per cycle; each row is one ship, and a 1 bit marks an intact cell.
- Keeps a sticky sunk mask and a sunk count, pulses an event for each newly sunk ship, and raises `all_sunk` (game over) when every ship in play is destroyed.
- Sits between the hit-register matrix and the game-control FSM; replaces the single-cycle all-rows check.

Parameters:
- NUM_SHIPS, 5, number of ship rows (1..32).
- SHIP_W, 5, cells per ship row (max ship length).
- IDX_W, $clog2(NUM_SHIPS) (min 1), width of the ship index.
- CNT_W, $clog2(NUM_SHIPS+1), width of the sunk count.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  new game: clear mask, count and flags; abort any scan.
- start  in  1  request a full scan pass; ignored while busy.
- barcos  in  [NUM_SHIPS-1:0][SHIP_W-1:0]  ship-cell matrix, row j = ship j, 1 = cell intact.
- ship_valid  in  NUM_SHIPS  ship j is placed and in play.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse at the end of a pass.
- new_sunk  out  1  one-cycle pulse: a ship newly detected sunk.
- new_sunk_idx  out  IDX_W  index of that ship; valid only while new_sunk=1.
- sunk_mask  out  NUM_SHIPS  sticky; bit j = ship j destroyed.
- sunk_count  out  CNT_W  popcount of sunk_mask.
- all_sunk  out  1  every valid ship is sunk.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, idx=0.
  - busy, done, new_sunk, new_sunk_idx, sunk_mask, sunk_count and all_sunk are all 0.
  - Reset mid-scan aborts the scan with the same result.
- Priority: rst > clear > start.
  - clear behaves like reset for all outputs and state.
  - clear during SCAN returns to IDLE with no done pulse.
- States: IDLE, SCAN, DONE. All outputs are registered.
- IDLE:
  - start=1 -> SCAN, idx=0, busy=1 from the next cycle.
- SCAN (one row per cycle):
  - Row idx is sunk-new when ship_valid[idx]=1, barcos[idx]=0 and sunk_mask[idx]=0.
  - On sunk-new, at the same edge: set sunk_mask[idx], increment sunk_count, new_sunk=1, new_sunk_idx=idx.
  - Otherwise new_sunk=0.
  - If idx==NUM_SHIPS-1 -> DONE; else idx+1.
- DONE (one cycle):
  - done=1, busy=0, new_sunk=0.
  - all_sunk <= (ship_valid!=0) && ((sunk_mask & ship_valid)==ship_valid).
  - Then -> IDLE.
- Latency:
  - start sampled at edge t -> new_sunk for row j visible after edge t+1+j.
  - done and all_sunk updated after edge t+NUM_SHIPS+1.
  - A pass is NUM_SHIPS+1 cycles; back-to-back passes need start in the cycle after done.
- barcos and ship_valid are sampled live, row by row; a row that changes mid-pass is evaluated at its own scan cycle.
- Sticky rules:
  - A mask bit never clears except on rst/clear, even if the row becomes nonzero again.
  - A sunk ship is reported by new_sunk at most once per game.
- Invalid ships (ship_valid=0) are never marked sunk, even if their row is 0.
- Arithmetic:
  - sunk_count saturates at NUM_SHIPS; by construction it cannot exceed that.
  - No wrap-around on idx beyond NUM_SHIPS-1.
- start while busy or in DONE is ignored; it is not queued.
- all_sunk updates only at DONE and holds between passes.

Decomposition:
- Package battleship_pkg:
  - Constants NUM_SHIPS_DEF=5 and SHIP_W_DEF=5.
  - typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t.
  - typedef for the ship-row vector.
- No sub-module: the row check is a single zero-compare.

Test Plan:
- Reset then idle: all outputs 0; start with barcos all 5'b11111 and ship_valid=5'b11111 -> done exactly 6 cycles after start, no new_sunk, sunk_mask=0, all_sunk=0.
- barcos[1]=0 and barcos[3]=0, valid=5'b11111, start -> new_sunk at cycles 2 (idx=1) and 4 (idx=3); sunk_mask=5'b01010, sunk_count=2.
- Repeat start with the same matrix -> no new_sunk pulses; mask and count unchanged; then set barcos[1]=5'b00100 -> mask bit 1 stays 1.
- All rows 0, ship_valid=5'b00111 -> sunk_mask=5'b00111, count=3, all_sunk=1 at done; ship_valid=0 with all rows 0 -> all_sunk=0, mask=0.
- Assert clear at scan cycle 3 -> next cycle busy=0, mask=0, count=0, no done; then rst mid-scan -> all outputs 0, IDLE.
- Parameter sweep NUM_SHIPS=8, SHIP_W=4: only row 7 zero -> new_sunk_idx=7 at cycle 8, done at cycle 9, sunk_count=1; start during busy is ignored.
